// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one pipelined sprite ROM read port among NREQ
// animation units; returns ROM data tagged with the requester index.
module sprite_fetch_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 2,
    parameter int IDX_W   = 12,
    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    frame_start_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*32-1:0]      offset_i,
    input  logic [NREQ*IDX_W-1:0]   pixel_idx_i,
    output logic [NREQ-1:0]         grant_o,
    output logic                    rom_rd_o,
    output logic [ADDR_W-1:0]       rom_addr_o,
    input  logic [DATA_W-1:0]       rom_q_i,
    output logic                    rdata_valid_o,
    output logic [ID_W-1:0]         rdata_id_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    addr_err_o
);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   start;
    logic [ID_W-1:0]   win;
    logic              found;
    logic              fire;
    logic [31:0]       sel_off;
    logic [IDX_W-1:0]  sel_idx;
    logic [32:0]       sum;
    logic              ovf;

    logic              rom_rd_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ID_W-1:0]   rd_id_q;
    logic              err_q;
    logic              vld_q [ROM_LAT];
    logic [ID_W-1:0]   id_q  [ROM_LAT];

    // frame_start restarts the search at 0 so every frame arbitrates alike
    always_comb begin
        start = frame_start_i ? '0 : ptr_q;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(start) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_i[j]) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
        fire    = found & rst_ni;
        grant_o = '0;
        if (fire) grant_o[win] = 1'b1;
        sel_off = offset_i[32*int'(win) +: 32];
        sel_idx = pixel_idx_i[IDX_W*int'(win) +: IDX_W];
        sum     = {1'b0, sel_off} + {{(33-IDX_W){1'b0}}, sel_idx};
        ovf     = |sum[32:ADDR_W];
        if (fire)               ptr_d = ID_W'((int'(win) + 1) % NREQ);
        else if (frame_start_i) ptr_d = '0;
        else                    ptr_d = ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_id_q    <= '0;
            err_q      <= 1'b0;
            for (int k = 0; k < ROM_LAT; k++) begin
                vld_q[k] <= 1'b0;
                id_q[k]  <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            rom_rd_q <= fire;
            if (fire) begin
                rom_addr_q <= ovf ? '0 : sum[ADDR_W-1:0];
                rd_id_q    <= win;
            end
            if (fire && ovf) err_q <= 1'b1;
            // return tracker is loaded in the ROM read cycle itself
            vld_q[0] <= rom_rd_q;
            id_q[0]  <= rd_id_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
        end
    end

    assign rom_rd_o      = rom_rd_q;
    assign rom_addr_o    = rom_addr_q;
    assign addr_err_o    = err_q;
    assign rdata_valid_o = vld_q[ROM_LAT-1];
    assign rdata_id_o    = id_q[ROM_LAT-1];
    assign rdata_o       = rom_q_i;

endmodule
